// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential ROM reads from a fetch PC,
// buffers returned words with their addresses in a 2-entry FIFO, and
// presents the FIFO head to the processor over a valid/ready handshake.
// Supports fetch redirection (flush + restart) and a halt level that
// stops new requests while letting outstanding work drain.
module fetch_unit #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt
);

    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);

    // Fetch state
    logic [ADDR_W-1:0] pc_r;
    logic              inflight_r;
    logic [ADDR_W-1:0] req_pc_r;

    // FIFO as two fixed slots; slot 0 is always the head so the
    // processor-facing outputs are plain register outputs.
    logic              v0_r;
    logic              v1_r;
    logic [DATA_W-1:0] d0_r;
    logic [DATA_W-1:0] d1_r;
    logic [ADDR_W-1:0] p0_r;
    logic [ADDR_W-1:0] p1_r;

    logic              xfer_s;
    logic              push_s;
    logic [2:0]        occ_s;
    logic              room_s;

    assign instr       = d0_r;
    assign instr_pc    = p0_r;
    assign instr_valid = v0_r;
    assign rom_addr    = pc_r;

    // Request gating: occupancy counts buffered entries plus the response
    // already on its way, and a head leaving this cycle frees one slot.
    always_comb begin
        xfer_s = v0_r & instr_ready;
        push_s = inflight_r & ~redirect;
        occ_s  = {2'b00, v0_r} + {2'b00, v1_r} + {2'b00, inflight_r};
        if (occ_s < (3'd2 + {2'b00, xfer_s})) begin
            room_s = 1'b1;
        end else begin
            room_s = 1'b0;
        end
        if (!rst && !halt && !redirect && room_s) begin
            rom_en = 1'b1;
        end else begin
            rom_en = 1'b0;
        end
    end

    // Fetch PC, in-flight tracking and FIFO slot movement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r       <= RESET_ADDR;
            inflight_r <= 1'b0;
            req_pc_r   <= '0;
            v0_r       <= 1'b0;
            v1_r       <= 1'b0;
            d0_r       <= '0;
            d1_r       <= '0;
            p0_r       <= '0;
            p1_r       <= '0;
        end else begin
            inflight_r <= rom_en;
            if (rom_en) begin
                req_pc_r <= pc_r;
            end

            if (redirect) begin
                pc_r <= redirect_pc;
            end else if (rom_en) begin
                pc_r <= pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end

            if (redirect) begin
                // Flush everything; a response landing now is stale.
                v0_r <= 1'b0;
                v1_r <= 1'b0;
            end else begin
                case ({xfer_s, push_s})
                    2'b11: begin
                        if (v1_r) begin
                            d0_r <= d1_r;
                            p0_r <= p1_r;
                            d1_r <= rom_data;
                            p1_r <= req_pc_r;
                        end else begin
                            d0_r <= rom_data;
                            p0_r <= req_pc_r;
                        end
                    end
                    2'b10: begin
                        v0_r <= v1_r;
                        v1_r <= 1'b0;
                        d0_r <= d1_r;
                        p0_r <= p1_r;
                    end
                    2'b01: begin
                        if (v0_r) begin
                            v1_r <= 1'b1;
                            d1_r <= rom_data;
                            p1_r <= req_pc_r;
                        end else begin
                            v0_r <= 1'b1;
                            d0_r <= rom_data;
                            p0_r <= req_pc_r;
                        end
                    end
                    default: begin
                        v0_r <= v0_r;
                        v1_r <= v1_r;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit. The reference model
// tracks, in plain counters, how many fetched words are buffered and
// whether one is in the air, and the expected delivery address stream.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic        halt;
    logic        redirect;
    logic [7:0]  rpc;

    logic        rom_en;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;

    logic        rom_en2;
    logic [7:0]  rom_addr2;
    logic [15:0] rom_data2;
    logic [15:0] instr2;
    logic [7:0]  instr_pc2;
    logic        instr_valid2;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    int          fifo_n;
    bit          pend;
    logic [7:0]  m_fpc;
    logic [7:0]  exp_pc;
    logic [7:0]  exp_pc2;
    int          n2;
    bit          hold_prev;
    logic [15:0] hold_instr;
    logic [7:0]  hold_pc;
    logic        s_valid;
    logic [15:0] s_instr;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(8), .DATA_W(16), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .rom_en(rom_en), .rom_addr(rom_addr),
        .rom_data(rom_data), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(ready),
        .redirect(redirect), .redirect_pc(rpc), .halt(halt)
    );

    fetch_unit #(.ADDR_W(8), .DATA_W(16), .RESET_PC(254)) dut_fe (
        .clk(clk), .rst(rst), .rom_en(rom_en2), .rom_addr(rom_addr2),
        .rom_data(rom_data2), .instr(instr2), .instr_pc(instr_pc2),
        .instr_valid(instr_valid2), .instr_ready(1'b1),
        .redirect(1'b0), .redirect_pc(8'h00), .halt(1'b0)
    );

    // ROM: word at address a is 0x1000 + a, one cycle after the request;
    // junk otherwise so timing errors show up.
    always @(posedge clk) begin
        rom_data  <= rom_en  ? (16'h1000 + {8'h00, rom_addr})  : 16'($urandom);
        rom_data2 <= rom_en2 ? (16'h1000 + {8'h00, rom_addr2}) : 16'($urandom);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        fifo_n    = 0;
        pend      = 1'b0;
        m_fpc     = 8'h00;
        exp_pc    = 8'h00;
        exp_pc2   = 8'hFE;
        hold_prev = 1'b0;
    endtask

    // One clock cycle: drive inputs at the falling edge, check just after,
    // then advance the model across the coming rising edge.
    task automatic cyc(input bit r_rst, input bit r_ready, input bit r_halt,
                       input bit r_redir, input logic [7:0] r_pc);
        bit exp_valid;
        bit xfer;
        bit exp_en;
        @(negedge clk);
        rst = r_rst; ready = r_ready; halt = r_halt; redirect = r_redir; rpc = r_pc;
        #1;
        s_valid = instr_valid;
        s_instr = instr;
        if (rst) begin
            chk("rst_rom_en", 32'(rom_en), 32'd0);
            chk("rst_valid", 32'(instr_valid), 32'd0);
            chk("rst_instr", 32'(instr), 32'd0);
            chk("rst_pc", 32'(instr_pc), 32'd0);
            chk("rst_valid2", 32'(instr_valid2), 32'd0);
            model_reset();
        end else begin
            exp_valid = (fifo_n > 0);
            xfer      = exp_valid && ready;
            exp_en    = !halt && !redirect && ((fifo_n + int'(pend) - int'(xfer)) < 2);
            chk("valid", 32'(instr_valid), 32'(exp_valid));
            chk("rom_en", 32'(rom_en), 32'(exp_en));
            if (exp_en) chk("rom_addr", 32'(rom_addr), 32'(m_fpc));
            if (xfer) begin
                chk("instr_pc", 32'(instr_pc), 32'(exp_pc));
                chk("instr", 32'(instr), 32'(16'h1000 + {8'h00, exp_pc}));
                exp_pc = exp_pc + 8'd1;
            end
            if (hold_prev) begin
                chk("hold_instr", 32'(instr), 32'(hold_instr));
                chk("hold_pc", 32'(instr_pc), 32'(hold_pc));
            end
            if (instr_valid2) begin
                chk("fe_pc", 32'(instr_pc2), 32'(exp_pc2));
                chk("fe_instr", 32'(instr2), 32'(16'h1000 + {8'h00, exp_pc2}));
                exp_pc2 = exp_pc2 + 8'd1;
                n2++;
            end
            hold_prev  = exp_valid && !ready && !redirect;
            hold_instr = instr;
            hold_pc    = instr_pc;
            if (redirect) begin
                fifo_n = 0;
                pend   = 1'b0;
                m_fpc  = rpc;
                exp_pc = rpc;
            end else begin
                fifo_n = fifo_n - int'(xfer) + int'(pend);
                pend   = exp_en;
                if (exp_en) m_fpc = m_fpc + 8'd1;
            end
        end
    endtask

    // Reset asserted between clock edges: outputs must drop immediately.
    task automatic areset();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_rom_en", 32'(rom_en), 32'd0);
        chk("arst_valid", 32'(instr_valid), 32'd0);
        chk("arst_instr", 32'(instr), 32'd0);
        chk("arst_rom_en2", 32'(rom_en2), 32'd0);
        model_reset();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        rst = 1'b1; ready = 1'b0; halt = 1'b0; redirect = 1'b0; rpc = 8'h00;
        n2 = 0;
        model_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

        // Startup latency: request in cycle 0, valid in cycle 2.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("first_valid", 32'(s_valid), 32'd1);
        chk("first_instr", 32'(s_instr), 32'h1000);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

        // Backpressure then release.
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

        // Redirect with two entries buffered.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h40);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

        // Halt mid-stream, then resume.
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

        // Asynchronous reset mid-stream.
        areset();
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 9) < 7),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 19) == 0),
                8'($urandom));
        end

        chk("fe_delivered", 32'(n2 >= 4), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
